// File: rtl/algebraic_window_table.sv
// Per-pixel threshold window table: a coarse peak bin becomes a clamped
// [lo, hi] window around the bin centre, stored per pixel with a valid bit.
module algebraic_window_table #(
    parameter int NB = 8,
    parameter int NP = 16,
    parameter int PIXEL_NUM = 16,
    parameter int HALF_WIN = 1 << (NP - NB),
    localparam int PW = $clog2(PIXEL_NUM)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          peak_valid,
    input  logic [NB-1:0] peak_ch,
    input  logic [PW-1:0] peak_pix,
    output logic          peak_ready,
    input  logic          frame_clr,
    input  logic          rd_en,
    input  logic [PW-1:0] rd_pix,
    output logic          rd_valid,
    output logic          rd_hit,
    output logic [NP-1:0] rd_th_minus,
    output logic [NP-1:0] rd_th_positive,
    output logic [NP-1:0] rd_delta,
    output logic [1:0]    rd_clip,
    output logic          all_done,
    output logic [PW:0]   pix_count
);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [NP-1:0] HW = NP'(HALF_WIN);
    localparam logic [NP-1:0] MAXV = '1;
    localparam logic [NP-1:0] HALF_BIN = NP'(1) << (NP - NB - 1);
    localparam logic [PW:0] NPIX = (PW + 1)'(PIXEL_NUM);
    localparam logic [PW:0] NPIX_M1 = (PW + 1)'(PIXEL_NUM - 1);
    localparam logic [PW-1:0] LAST = PW'(PIXEL_NUM - 1);

    state_t state, state_nx;

    logic [PW-1:0] init_idx;
    logic          s1_v;
    logic [NP-1:0] s1_ch;
    logic [PW-1:0] s1_pix;
    logic [PIXEL_NUM-1:0] vbits;

    logic [NP-1:0] tm_q [PIXEL_NUM];
    logic [NP-1:0] tp_q [PIXEL_NUM];
    logic [NP-1:0] dl_q [PIXEL_NUM];
    logic [1:0]    cl_q [PIXEL_NUM];

    logic          accept;
    logic          clr;
    logic          wr_en;
    logic          new_pix;
    logic          rd_sel;
    logic [NP-1:0] ch_in;
    logic [NP-1:0] lo;
    logic [NP-1:0] hi;
    logic [NP-1:0] dl;
    logic [1:0]    clip;

    assign peak_ready = (state != S_INIT);
    assign all_done   = (state == S_DONE);

    assign accept  = peak_valid && peak_ready && ({1'b0, peak_pix} < NPIX);
    assign clr     = frame_clr && (state != S_INIT);
    assign wr_en   = s1_v && !clr;
    assign new_pix = wr_en && !vbits[s1_pix];
    assign ch_in   = {peak_ch, {(NP - NB){1'b0}}} + HALF_BIN;
    assign rd_sel  = rd_en && ({1'b0, rd_pix} < NPIX) && vbits[rd_pix];

    // Bounds are tested before subtracting/adding so nothing wraps.
    always_comb begin
        lo   = '0;
        hi   = HW + HW;
        clip = 2'b01;
        if (s1_ch <= HW) begin
            lo   = '0;
            hi   = HW + HW;
            clip = 2'b01;
        end else if (s1_ch >= MAXV - HW) begin
            lo   = MAXV - (HW + HW);
            hi   = MAXV;
            clip = 2'b10;
        end else begin
            lo   = s1_ch - HW;
            hi   = s1_ch + HW;
            clip = 2'b00;
        end
        dl = s1_ch - lo;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_INIT: if (init_idx == LAST) state_nx = S_RUN;
            S_RUN: begin
                if (!clr && new_pix && pix_count == NPIX_M1)
                    state_nx = S_DONE;
            end
            S_DONE: if (clr) state_nx = S_RUN;
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state     <= S_INIT;
            init_idx  <= '0;
            s1_v      <= 1'b0;
            s1_ch     <= '0;
            s1_pix    <= '0;
            vbits     <= '0;
            pix_count <= '0;
        end else begin
            state <= state_nx;
            if (state == S_INIT) init_idx <= init_idx + PW'(1);
            s1_v <= accept;
            if (accept) begin
                s1_ch  <= ch_in;
                s1_pix <= peak_pix;
            end
            if (clr) begin
                vbits     <= '0;
                pix_count <= '0;
            end else if (new_pix) begin
                vbits[s1_pix] <= 1'b1;
                pix_count     <= pix_count + (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            if (state == S_INIT) begin
                tm_q[init_idx] <= '0;
                tp_q[init_idx] <= '0;
                dl_q[init_idx] <= '0;
                cl_q[init_idx] <= '0;
            end else if (wr_en) begin
                tm_q[s1_pix] <= lo;
                tp_q[s1_pix] <= hi;
                dl_q[s1_pix] <= dl;
                cl_q[s1_pix] <= clip;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            rd_valid       <= 1'b0;
            rd_hit         <= 1'b0;
            rd_th_minus    <= '0;
            rd_th_positive <= '0;
            rd_delta       <= '0;
            rd_clip        <= '0;
        end else begin
            rd_valid       <= rd_en;
            rd_hit         <= rd_sel;
            rd_th_minus    <= rd_sel ? tm_q[rd_pix] : '0;
            rd_th_positive <= rd_sel ? tp_q[rd_pix] : '0;
            rd_delta       <= rd_sel ? dl_q[rd_pix] : '0;
            rd_clip        <= rd_sel ? cl_q[rd_pix] : '0;
        end
    end

endmodule

// File: tb/tb_algebraic_window_table.sv
// Directed bench for algebraic_window_table with hand-computed windows.
module tb_algebraic_window_table;

    logic        clk = 1'b0;
    logic        res;
    logic        peak_valid;
    logic [7:0]  peak_ch;
    logic [3:0]  peak_pix;
    logic        peak_ready;
    logic        frame_clr;
    logic        rd_en;
    logic [3:0]  rd_pix;
    logic        rd_valid;
    logic        rd_hit;
    logic [15:0] rd_th_minus;
    logic [15:0] rd_th_positive;
    logic [15:0] rd_delta;
    logic [1:0]  rd_clip;
    logic        all_done;
    logic [4:0]  pix_count;

    int errors = 0;
    int checks = 0;

    algebraic_window_table #(
        .NB(8),
        .NP(16),
        .PIXEL_NUM(16),
        .HALF_WIN(256)
    ) dut (
        .clk(clk),
        .res(res),
        .peak_valid(peak_valid),
        .peak_ch(peak_ch),
        .peak_pix(peak_pix),
        .peak_ready(peak_ready),
        .frame_clr(frame_clr),
        .rd_en(rd_en),
        .rd_pix(rd_pix),
        .rd_valid(rd_valid),
        .rd_hit(rd_hit),
        .rd_th_minus(rd_th_minus),
        .rd_th_positive(rd_th_positive),
        .rd_delta(rd_delta),
        .rd_clip(rd_clip),
        .all_done(all_done),
        .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] pix);
        rd_en  = 1'b1;
        rd_pix = pix;
        step();
        rd_en  = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic hit,
                          input logic [15:0] tm, input logic [15:0] tp,
                          input logic [15:0] dl, input logic [1:0] cl);
        chk({tag, ".valid"}, 32'(rd_valid), 32'(1'b1));
        chk({tag, ".hit"}, 32'(rd_hit), 32'(hit));
        chk({tag, ".th_minus"}, 32'(rd_th_minus), 32'(tm));
        chk({tag, ".th_positive"}, 32'(rd_th_positive), 32'(tp));
        chk({tag, ".delta"}, 32'(rd_delta), 32'(dl));
        chk({tag, ".clip"}, 32'(rd_clip), 32'(cl));
    endtask

    task automatic peak(input logic [7:0] ch, input logic [3:0] pix);
        peak_valid = 1'b1;
        peak_ch    = ch;
        peak_pix   = pix;
        step();
        peak_valid = 1'b0;
    endtask

    initial begin
        res        = 1'b0;
        peak_valid = 1'b0;
        peak_ch    = '0;
        peak_pix   = '0;
        frame_clr  = 1'b0;
        rd_en      = 1'b0;
        rd_pix     = '0;

        repeat (3) step();
        chk("rst.ready", 32'(peak_ready), 0);
        chk("rst.done", 32'(all_done), 0);
        chk("rst.count", 32'(pix_count), 0);
        chk("rst.rd_valid", 32'(rd_valid), 0);

        // Init sweep: ready stays low for 16 cycles, frame_clr ignored
        res = 1'b1;
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        chk("init.ready1", 32'(peak_ready), 0);
        repeat (14) step();
        chk("init.ready15", 32'(peak_ready), 0);
        step();
        chk("init.ready16", 32'(peak_ready), 1);

        rd(4'd3);
        chk_rd("empty3", 1'b0, 16'h0, 16'h0, 16'h0, 2'b00);
        step();
        chk("rd.one_cycle", 32'(rd_valid), 0);

        // Mid-range window; a read one edge after acceptance is too early
        peak(8'h40, 4'd2);
        rd(4'd2);
        chk_rd("early2", 1'b0, 16'h0, 16'h0, 16'h0, 2'b00);
        rd(4'd2);
        chk_rd("mid2", 1'b1, 16'h3F80, 16'h4180, 16'h0100, 2'b00);
        chk("mid.count", 32'(pix_count), 1);

        // Low and high clamps, back to back
        peak(8'h00, 4'd0);
        peak(8'hFF, 4'd1);
        step();
        rd(4'd0);
        chk_rd("lo0", 1'b1, 16'h0000, 16'h0200, 16'h0080, 2'b01);
        rd(4'd1);
        chk_rd("hi1", 1'b1, 16'hFDFF, 16'hFFFF, 16'h0181, 2'b10);
        chk("clamp.count", 32'(pix_count), 3);

        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        chk("clr.count", 32'(pix_count), 0);
        rd(4'd2);
        chk_rd("clr2", 1'b0, 16'h0, 16'h0, 16'h0, 2'b00);

        // Fill all 16 pixels back to back
        for (int i = 0; i < 16; i++) peak(8'(i * 3), 4'(i));
        chk("fill.count15", 32'(pix_count), 15);
        chk("fill.done15", 32'(all_done), 0);
        step();
        chk("fill.count16", 32'(pix_count), 16);
        chk("fill.done16", 32'(all_done), 1);
        chk("done.ready", 32'(peak_ready), 1);

        peak(8'h80, 4'd5);
        step();
        chk("rewr.count", 32'(pix_count), 16);
        chk("rewr.done", 32'(all_done), 1);
        rd(4'd5);
        chk_rd("rewr5", 1'b1, 16'h7F80, 16'h8180, 16'h0100, 2'b00);

        // Peak accepted one edge before frame_clr is squashed
        peak_valid = 1'b1;
        peak_ch    = 8'h30;
        peak_pix   = 4'd7;
        step();
        peak_valid = 1'b0;
        frame_clr  = 1'b1;
        step();
        frame_clr  = 1'b0;
        step();
        rd(4'd7);
        chk_rd("squash7", 1'b0, 16'h0, 16'h0, 16'h0, 2'b00);
        chk("squash.count", 32'(pix_count), 0);
        chk("squash.done", 32'(all_done), 0);

        // Peak accepted on the frame_clr edge belongs to the new frame
        peak_valid = 1'b1;
        peak_ch    = 8'h10;
        peak_pix   = 4'd9;
        frame_clr  = 1'b1;
        step();
        peak_valid = 1'b0;
        frame_clr  = 1'b0;
        step();
        chk("same_clr.count", 32'(pix_count), 1);
        rd(4'd9);
        chk_rd("same_clr9", 1'b1, 16'h0F80, 16'h1180, 16'h0100, 2'b00);

        // Read on the write edge returns the old entry
        peak(8'h20, 4'd9);
        rd(4'd9);
        chk_rd("old9", 1'b1, 16'h0F80, 16'h1180, 16'h0100, 2'b00);
        rd(4'd9);
        chk_rd("new9", 1'b1, 16'h1F80, 16'h2180, 16'h0100, 2'b00);
        chk("rw.count", 32'(pix_count), 1);

        // Reset mid-init restarts the sweep from entry 0
        res = 1'b0;
        step();
        chk("rst2.ready", 32'(peak_ready), 0);
        chk("rst2.count", 32'(pix_count), 0);
        chk("rst2.rd_valid", 32'(rd_valid), 0);
        res = 1'b1;
        repeat (5) step();
        res = 1'b0;
        step();
        res = 1'b1;
        repeat (15) step();
        chk("rst3.ready15", 32'(peak_ready), 0);
        step();
        chk("rst3.ready16", 32'(peak_ready), 1);
        rd(4'd9);
        chk_rd("rst3.9", 1'b0, 16'h0, 16'h0, 16'h0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/algebraic_window_table.md
ALGEBRAIC_WINDOW_TABLE -- requirements
Module: algebraic_window_table

Interface
REQ-001 SHALL have parameter NB, default 8, coarse peak-bin index width.
REQ-002 SHALL have parameter NP, default 16, fine threshold width; NP > NB required.
REQ-003 SHALL have parameter PIXEL_NUM, default 16, pixels per table; PW = clog2(PIXEL_NUM).
REQ-004 SHALL have parameter HALF_WIN, default 1<<(NP-NB), window half-width; 2*HALF_WIN <= 2^NP-1 required.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port res  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports peak_valid in 1, peak_ch in NB, peak_pix in PW: coarse peak result and pixel index.
REQ-008 SHALL have port peak_ready  out  1  peak accepted when peak_valid&peak_ready at an edge.
REQ-009 SHALL have port frame_clr  in  1  single-cycle pulse that starts a new frame.
REQ-010 SHALL have ports rd_en in 1, rd_pix in PW: table read request.
REQ-011 SHALL have ports rd_valid out 1, rd_hit out 1, rd_th_minus out NP, rd_th_positive out NP, rd_delta out NP, rd_clip out 2 ([0]=low clamp, [1]=high clamp).
REQ-012 SHALL have ports all_done out 1 (every pixel written this frame) and pix_count out PW+1.

Function
REQ-013 SHALL run FSM INIT -> RUN -> DONE; INIT entered on reset.
REQ-014 INIT SHALL write zero to every entry over PIXEL_NUM cycles, then go to RUN; peak_ready=0 in INIT, 1 in RUN/DONE.
REQ-015 Accepted peak SHALL compute CH = (peak_ch << (NP-NB)) + (1 << (NP-NB-1)) (bin centre), NP-bit unsigned.
REQ-016 Clamp with MAX=2^NP-1: CH <= HALF_WIN -> lo=0, hi=2*HALF_WIN, clip=01; CH >= MAX-HALF_WIN -> hi=MAX, lo=MAX-2*HALF_WIN, clip=10; else lo=CH-HALF_WIN, hi=CH+HALF_WIN, clip=00.
REQ-017 SHALL store th_minus=lo, th_positive=hi, delta=CH-lo, clip; no intermediate may wrap.
REQ-018 Pipeline: stage 1 registers CH/pix on the acceptance edge; stage 2 writes the table on the next edge (2-edge write latency, throughput 1/cycle).
REQ-019 First write to a pixel in a frame SHALL set its valid bit and increment pix_count; rewrite of a valid pixel SHALL update data only.
REQ-020 When pix_count reaches PIXEL_NUM, FSM SHALL enter DONE and all_done=1 until frame_clr; peaks still accepted and overwrite entries in DONE.
REQ-021 frame_clr in RUN/DONE SHALL clear all valid bits and pix_count, go to RUN, and squash stage-1/stage-2 entries accepted before that edge; a peak accepted on the frame_clr edge belongs to the new frame.
REQ-022 frame_clr in INIT SHALL be ignored.
REQ-023 Read: rd_en sampled at edge k -> rd_valid=1 and data after edge k for one cycle; data = table before that edge's write (no bypass).
REQ-024 rd_hit = valid bit of rd_pix; rd_hit=0 SHALL force rd_th_minus/rd_th_positive/rd_delta/rd_clip to 0.
REQ-025 rd_pix or peak_pix >= PIXEL_NUM SHALL be ignored (no write; read returns rd_hit=0).

Reset
REQ-026 res=0 at an edge SHALL force FSM=INIT, peak_ready=0, rd_valid=0, rd_hit=0, all read data 0, all_done=0, pix_count=0, valid bits 0, pipeline emptied; reset mid-INIT restarts the sweep from entry 0.

Verification (NB=8, NP=16, PIXEL_NUM=16, HALF_WIN=256)
REQ-027 Reset release -> peak_ready=0 for 16 cycles then 1; read of pixel 3 -> rd_hit=0, data 0.
REQ-028 peak_ch=0x40, pix 2 -> read 2 edges later: th_minus=0x3F80, th_positive=0x4180, delta=0x0100, clip=00.
REQ-029 peak_ch=0x00, pix 0 -> th_minus=0, th_positive=0x0200, delta=0x0080, clip=01; peak_ch=0xFF, pix 1 -> th_positive=0xFFFF, th_minus=0xFDFF, delta=0x0181, clip=10.
REQ-030 16 distinct pixels back-to-back, then pixel 5 rewritten -> pix_count=16, all_done=1, count unchanged by rewrite.
REQ-031 peak accepted on edge k, frame_clr on edge k+1 -> pixel not valid, pix_count=0; peak on the frame_clr edge -> valid, pix_count=1.
REQ-032 rd_en on the same edge as write to that pixel -> old data returned; next read returns new data.
